// File: rtl/cmp_lteq_rr_arbiter.sv
// Round-robin front end for one shared signed a<=b comparator.
// Stage 1 registers the granted operands, which drive the comparator.
// Stage 2 registers the result and presents it, tagged with the requester ID,
// on a valid/ready response port. A saturating counter tracks completed responses.
module cmp_lteq_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = $clog2(NREQ),
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]      cmp_a,
  output logic [WIDTH-1:0]      cmp_b,
  input  logic                  cmp_lteq,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_lteq,
  output logic [CNT_W-1:0]      cmp_count
);

  logic              s1_valid;
  logic [IDW-1:0]    s1_id;
  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    next_ptr;

  logic              s2_free;
  logic              s1_move;
  logic              accept_ok;
  logic              rsp_fire;

  logic [2*NREQ-1:0] valid_dbl;
  logic [NREQ-1:0]   valid_rot;
  logic [IDW:0]      idx_sum;
  logic              grant_found;
  logic [IDW-1:0]    grant_id;
  logic              do_grant;
  logic [WIDTH-1:0]  grant_a;
  logic [WIDTH-1:0]  grant_b;

  assign s2_free   = !rsp_valid || rsp_ready;
  assign s1_move   = s1_valid && s2_free;
  assign accept_ok = !s1_valid || s1_move;
  assign rsp_fire  = rsp_valid && rsp_ready;

  // A grant is suppressed during reset so no requester sees a handshake that the reset then discards.
  assign do_grant  = accept_ok && grant_found && !rst;
  assign next_ptr  = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

  // Rotate the request vector so that the pointer position sits at bit 0, take the first set bit, then map back.
  always_comb begin
    valid_dbl   = {req_valid, req_valid};
    valid_rot   = NREQ'(valid_dbl >> rr_ptr);
    grant_found = 1'b0;
    idx_sum     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && valid_rot[i]) begin
        grant_found = 1'b1;
        idx_sum     = {1'b0, rr_ptr} + (IDW+1)'(i);
      end
    end
    if (idx_sum >= (IDW+1)'(NREQ)) begin
      idx_sum = idx_sum - (IDW+1)'(NREQ);
    end
    grant_id = idx_sum[IDW-1:0];
  end

  // Select the winner's operands and raise its ready; ready is at most one-hot.
  always_comb begin
    grant_a   = '0;
    grant_b   = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        grant_a      = req_a[i*WIDTH +: WIDTH];
        grant_b      = req_b[i*WIDTH +: WIDTH];
        req_ready[i] = do_grant;
      end
    end
  end

  // Stage 1: hold the granted operands for the comparator and advance the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      cmp_a    <= '0;
      cmp_b    <= '0;
      rr_ptr   <= '0;
    end else if (do_grant) begin
      s1_valid <= 1'b1;
      s1_id    <= grant_id;
      cmp_a    <= grant_a;
      cmp_b    <= grant_b;
      rr_ptr   <= next_ptr;
    end else if (s1_move) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: capture the comparator result when stage 1 moves, otherwise hold until the consumer accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_lteq  <= 1'b0;
    end else if (s1_move) begin
      rsp_valid <= 1'b1;
      rsp_id    <= s1_id;
      rsp_lteq  <= cmp_lteq;
    end else if (rsp_fire) begin
      rsp_valid <= 1'b0;
    end
  end

  // Count completed response handshakes, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_count <= '0;
    end else if (rsp_fire && (cmp_count != {CNT_W{1'b1}})) begin
      cmp_count <= cmp_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cmp_lteq_rr_arbiter.sv
// Bench for cmp_lteq_rr_arbiter: per-requester stimulus queues, a scoreboard filled on
// request handshakes and drained on response handshakes, plus directed timing checks.
module tb_cmp_lteq_rr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int IDW   = 2;
  localparam int CNT_W = 4;
  localparam int DEPTH = 64;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic [WIDTH-1:0]      cmp_a;
  logic [WIDTH-1:0]      cmp_b;
  logic                  cmp_lteq;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_lteq;
  logic [CNT_W-1:0]      cmp_count;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [WIDTH-1:0] qa [NREQ][DEPTH];
  logic [WIDTH-1:0] qb [NREQ][DEPTH];
  int               head [NREQ];
  int               tail [NREQ];
  logic [NREQ-1:0]  took = '0;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           lteq;
    int             acc;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   gcyc[$];

  logic           chk_lat   = 1'b1;
  logic           hold_prev = 1'b0;
  logic [IDW-1:0] prev_id   = '0;
  logic           prev_lteq = 1'b0;

  cmp_lteq_rr_arbiter #(
    .NREQ (NREQ),
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .cmp_a    (cmp_a),
    .cmp_b    (cmp_b),
    .cmp_lteq (cmp_lteq),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_lteq (rsp_lteq),
    .cmp_count(cmp_count)
  );

  // Behavioural stand-in for the shared comparator.
  assign cmp_lteq = ($signed(cmp_a) <= $signed(cmp_b));

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to measure grant spacing and response latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    qa[id][tail[id]] = a;
    qb[id][tail[id]] = b;
    tail[id]++;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    tick();
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    took = '0;
    sb.delete();
    tick();
    rst = 1'b0;
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NREQ; i++) n += tail[i] - head[i];
    return n;
  endfunction

  task automatic drain();
    int n;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (pending() == 0 && took == '0 && sb.size() == 0 && !rsp_valid) break;
    end
    checkOutput("drain_done", 64'(n < 300), 64'(1));
  endtask

  // Requesters: present the head of each queue and hold it until the monitor saw it accepted.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (took[i]) begin
        head[i]++;
        took[i] = 1'b0;
      end
      if (head[i] < tail[i]) begin
        req_valid[i]              = 1'b1;
        req_a[i*WIDTH +: WIDTH]   = qa[i][head[i]];
        req_b[i*WIDTH +: WIDTH]   = qb[i][head[i]];
      end else begin
        req_valid[i]              = 1'b0;
        req_a[i*WIDTH +: WIDTH]   = '0;
        req_b[i*WIDTH +: WIDTH]   = '0;
      end
    end
  end

  // Monitor on the falling edge: record accepts into the scoreboard, check responses and hold behaviour.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      checkOutput("ready_legal",
                  64'($onehot0(req_ready) && ((req_ready & ~req_valid) == '0)), 64'(1));
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          took[i] = 1'b1;
          e.id    = IDW'(i);
          e.lteq  = ($signed(qa[i][head[i]]) <= $signed(qb[i][head[i]]));
          e.acc   = cyc;
          sb.push_back(e);
          grant_log.push_back(i);
          gcyc.push_back(cyc);
        end
      end
      if (hold_prev) begin
        checkOutput("hold_valid", 64'(rsp_valid), 64'(1));
        checkOutput("hold_id", 64'(rsp_id), 64'(prev_id));
        checkOutput("hold_lteq", 64'(rsp_lteq), 64'(prev_lteq));
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checkOutput("rsp_unexpected", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          checkOutput("rsp_id", 64'(rsp_id), 64'(e.id));
          checkOutput("rsp_lteq", 64'(rsp_lteq), 64'(e.lteq));
          if (chk_lat) checkOutput("latency", 64'(cyc - e.acc), 64'(2));
        end
      end
      hold_prev = rsp_valid && !rsp_ready;
      prev_id   = rsp_id;
      prev_lteq = rsp_lteq;
    end
  end

  // Safety net so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int  seen;
    logic [WIDTH-1:0] ra;

    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end

    doReset();
    @(negedge clk);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    checkOutput("reset_count", 64'(cmp_count), 64'(0));
    checkOutput("reset_cmp_a", 64'(cmp_a), 64'(0));
    checkOutput("reset_ready", 64'(req_ready), 64'(0));

    // Single request with equal operands.
    tick();
    applyStimulus(0, 32'd5, 32'd5);
    @(posedge clk);
    @(negedge clk);
    checkOutput("single_ready", 64'(req_ready), 64'(4'b0001));
    drain();
    checkOutput("single_count", 64'(cmp_count), 64'(1));

    // Signed extremes.
    tick();
    applyStimulus(0, 32'h8000_0000, 32'h7FFF_FFFF);
    applyStimulus(1, 32'h7FFF_FFFF, 32'h8000_0000);
    applyStimulus(2, 32'hFFFF_FFFF, 32'h0000_0000);
    drain();
    checkOutput("edges_count", 64'(cmp_count), 64'(4));

    // Round-robin with all requesters continuously valid.
    doReset();
    grant_log.delete();
    gcyc.delete();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        ra = $urandom;
        applyStimulus(i, ra, (k == 1) ? ra : $urandom);
      end
    end
    drain();
    checkOutput("rr_grants", 64'(grant_log.size()), 64'(12));
    for (int k = 0; k < grant_log.size() && k < 12; k++) begin
      checkOutput("rr_order", 64'(grant_log[k]), 64'(k % 4));
      checkOutput("rr_spacing", 64'(gcyc[k] - gcyc[0]), 64'(k));
    end
    checkOutput("rr_count", 64'(cmp_count), 64'(12));

    // Backpressure: pipe fills, then stalls with no further grants.
    chk_lat = 1'b0;
    tick();
    rsp_ready = 1'b0;
    applyStimulus(0, 32'd10, 32'd3);
    applyStimulus(1, 32'hFFFF_FFF0, 32'd1);
    applyStimulus(2, 32'd7, 32'd7);
    repeat (3) @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("stall_ready", 64'(req_ready), 64'(0));
      checkOutput("stall_valid", 64'(rsp_valid), 64'(1));
      checkOutput("stall_id", 64'(rsp_id), 64'(0));
      checkOutput("stall_lteq", 64'(rsp_lteq), 64'(0));
    end
    tick();
    rsp_ready = 1'b1;
    drain();
    checkOutput("bp_count", 64'(cmp_count), 64'(15));

    // Reset while both stages hold entries.
    tick();
    rsp_ready = 1'b0;
    applyStimulus(0, 32'd1, 32'd2);
    applyStimulus(1, 32'd3, 32'd4);
    applyStimulus(2, 32'd5, 32'd6);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("pre_reset_valid", 64'(rsp_valid), 64'(1));
    doReset();
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("midrst_valid", 64'(rsp_valid), 64'(0));
    checkOutput("midrst_count", 64'(cmp_count), 64'(0));
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checkOutput("no_stale_rsp", 64'(seen), 64'(0));

    // Saturation of the 4-bit counter; first grant also shows the pointer was reset.
    tick();
    grant_log.delete();
    gcyc.delete();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 32'h8000_0000, 32'h8000_0000);
      applyStimulus(1, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
      applyStimulus(2, $urandom, $urandom);
      applyStimulus(3, 32'hFFFF_FFFF, 32'h8000_0000);
    end
    drain();
    checkOutput("sat_grants", 64'(grant_log.size()), 64'(20));
    if (grant_log.size() > 0) checkOutput("ptr_after_reset", 64'(grant_log[0]), 64'(0));
    checkOutput("sat_count", 64'(cmp_count), 64'(15));
    checkOutput("sb_empty", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cmp_lteq_rr_arbiter.md
Name: cmp_lteq_rr_arbiter

Overview:
- Shares one combinational 32-bit signed less-than-or-equal comparator among NREQ requesters.
- Arbitrates round-robin, registers operands into the comparator, registers its result, and returns it with the requester ID over a valid/ready response port.
- Sits between client FSMs and the single comparator instance (a <= b, signed, one output bit).
- Keeps a saturating count of completed comparisons.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 32, operand width in bits (two's complement).
- IDW, clog2(NREQ), requester ID width (derived; do not override).
- CNT_W, 16, width of the completed-comparison counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*WIDTH  operand a, requester i at bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand b, same packing.
- cmp_a  out  WIDTH  operand a to the shared comparator (registered).
- cmp_b  out  WIDTH  operand b to the shared comparator (registered).
- cmp_lteq  in  1  comparator result, combinational from cmp_a/cmp_b.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_lteq  out  1  1 iff signed(a) <= signed(b).
- cmp_count  out  CNT_W  completed responses; saturates at all-ones.

Behaviour:
- Reset (synchronous, active-high) clears:
  - s1_valid, rsp_valid, rsp_id, rsp_lteq, cmp_a, cmp_b, cmp_count to 0.
  - RR pointer to 0.
  - req_ready to all-zero.
  - Reset mid-operation discards in-flight stage-1 and response entries; no response is emitted for them.
- Pipeline:
  - Stage 1 holds the granted operands and ID; cmp_a/cmp_b are driven from these registers.
  - Stage 2 is the response register.
  - Latency is exactly 2 cycles from the accept edge to rsp_valid=1 when there is no backpressure.
  - Throughput is 1 compare per cycle.
- Advance rules:
  - s2_free = !rsp_valid | rsp_ready.
  - s1_move = s1_valid & s2_free; on s1_move, rsp_lteq<=cmp_lteq, rsp_id<=s1_id, rsp_valid<=1.
  - If !s1_move and rsp_valid and rsp_ready, rsp_valid<=0.
  - accept_ok = !s1_valid | s1_move.
- Arbitration:
  - When accept_ok, grant the first requester with req_valid=1, searching from RR pointer upward with wrap.
  - req_ready[g]=1 combinationally for that cycle only.
  - On grant, capture req_a/req_b[g] and g into stage 1; set RR pointer to (g+1) mod NREQ.
  - If no request is valid or accept_ok=0: req_ready=0, pointer unchanged, and s1_valid<=0 if s1_move.
  - req_ready must not depend on rsp_ready except through s2_free.
- Handshake contract:
  - A requester holds req_valid and operands stable until its req_ready is seen.
  - rsp_valid/rsp_id/rsp_lteq stay stable while rsp_valid & !rsp_ready.
- Fairness: a continuously valid requester is granted within NREQ accepting cycles.
- cmp_count increments on each rsp_valid & rsp_ready handshake and holds at 2^CNT_W-1.
- Boundary conditions:
  - Full pipe with stalled response: both stages hold, no grants.
  - Response drained in the same cycle as an s1 move and a new grant: all three happen.
  - Pointer wrap from NREQ-1 to 0.
  - Equal operands give 1.
  - Most-negative vs most-positive operands obey signed order.
- Golden model: rsp_lteq = ($signed(a) <= $signed(b)). The bench instantiates a behavioural comparator on cmp_a/cmp_b.

Test Plan:
- Single request: after reset, req0 a=5, b=5 -> req_ready[0] in cycle 0; rsp_valid at cycle 2 with id=0, lteq=1; cmp_count=1 after handshake.
- Signed edges:
  - a=0x80000000, b=0x7FFFFFFF -> lteq=1.
  - a=0x7FFFFFFF, b=0x80000000 -> lteq=0.
  - a=0xFFFFFFFF (-1), b=0 -> lteq=1.
- Round-robin: all 4 requesters valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0,...; one response per cycle; ids follow the same order.
- Backpressure: hold rsp_ready=0 for 5 cycles with 2 requests outstanding -> response fields stable, no further req_ready; release -> responses resume in order with no loss or duplication.
- Reset mid-flight: assert rst while s1 and s2 are both valid -> next cycle rsp_valid=0, cmp_count=0, pointer=0, and no stale response afterwards.
- Saturation: CNT_W=4, complete 20 compares -> cmp_count sticks at 15.
